// File: rtl/controlador_dispensador_pkg.sv
// controlador_pkg: shared types and constants for the dispenser sequencer
package controlador_pkg;
    localparam int COIN_UNIT   = 10;
    localparam int PRICE_COINS = 30 / COIN_UNIT;
    typedef enum logic [2:0] {IDLE, MOTOR, GAP, COIN_ON, COIN_GAP, DONE} state_e;
    typedef struct packed {
        logic       vend;
        logic [1:0] change;
    } req_t;
    function automatic logic is_req(input req_t r);
        return r.vend || (r.change != 2'd0);
    endfunction
endpackage

// File: rtl/controlador_dispensador_if.sv
// controlador_dispensador_if: request/actuator bundle between vending FSM and dispenser
//   requests : vend_req, change_req[1:0], refill        (master -> slave)
//   status   : busy, motor, coin_out, done, lost, stock, empty (slave -> master)
interface controlador_dispensador_if #(
    parameter int STOCK_W = 4
);
    logic               vend_req;
    logic [1:0]         change_req;
    logic               refill;
    logic               busy;
    logic               motor;
    logic               coin_out;
    logic               done;
    logic               lost;
    logic [STOCK_W-1:0] stock;
    logic               empty;
    modport master (
        output vend_req, change_req, refill,
        input  busy, motor, coin_out, done, lost, stock, empty
    );
    modport slave (
        input  vend_req, change_req, refill,
        output busy, motor, coin_out, done, lost, stock, empty
    );
endinterface

// File: rtl/controlador_dispensador_temporizador.sv
// temporizador_ciclos: loadable down-counter shared by all timed states
//   clk, rst  clock, asynchronous active-low reset
//   start_i   load load_i on this edge
//   load_i    length in cycles of the interval being started
//   expire_o  high during the last cycle of the loaded interval
module temporizador_ciclos #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] load_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt_d    = start_i ? load_i : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    assign expire_o = cnt_q == W'(1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
endmodule

// File: rtl/controlador_dispensador.sv
// controlador_dispensador: timed product motor and coin ejector sequencer with stock tracking
//   clk, rst  clock, asynchronous active-low reset
//   bus       controlador_dispensador_if.slave (requests in, actuators/status out)
//   VEND_QUEUE_EN  when defined, one request arriving while busy is buffered instead of lost
module controlador_dispensador
    import controlador_pkg::*;
#(
    parameter int MOTOR_CYCLES = 8,
    parameter int COIN_CYCLES  = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int STOCK_W      = 4,
    parameter int STOCK_INIT   = 15
) (
    input logic                      clk,
    input logic                      rst,
    controlador_dispensador_if.slave bus
);
    localparam int MC = MOTOR_CYCLES > COIN_CYCLES ? MOTOR_CYCLES : COIN_CYCLES;
    localparam int TW = $clog2(MC > GAP_CYCLES ? MC : GAP_CYCLES) + 1;
    state_e             state_q, state_d;
    logic [2:0]         coins_q, coins_d;
    logic [STOCK_W-1:0] stock_q, stock_d;
    logic               lost_q, lost_d;
    logic               expire, cap_v, in_v, refill_ok, do_vend;
    logic [TW-1:0]      t_load;
    req_t               req_in, cap_req;
    assign req_in  = {bus.vend_req, bus.change_req};
    assign in_v    = is_req(req_in);
    assign do_vend = cap_req.vend && stock_q != '0;
`ifdef VEND_QUEUE_EN
    req_t pend_q, pend_d;
    logic pend_v_q, pend_v_d, from_pend;
    // A pending request is served at the DONE exit edge so busy never drops between them.
    assign from_pend = pend_v_q && (state_q == IDLE || state_q == DONE);
    assign cap_v     = from_pend || (state_q == IDLE && in_v);
    assign cap_req   = from_pend ? pend_q : req_in;
    assign refill_ok = state_q == IDLE && !in_v && !pend_v_q;
    assign lost_d    = in_v && pend_v_q && !from_pend;
    always_comb begin
        pend_v_d = pend_v_q;
        pend_d   = pend_q;
        if (from_pend) begin
            pend_v_d = in_v;
            pend_d   = req_in;
        end else if (in_v && state_q != IDLE && !pend_v_q) begin
            pend_v_d = 1'b1;
            pend_d   = req_in;
        end
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            pend_v_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            pend_v_q <= pend_v_d;
            pend_q   <= pend_d;
        end
`else
    assign cap_v     = state_q == IDLE && in_v;
    assign cap_req   = req_in;
    assign refill_ok = state_q == IDLE && !in_v;
    assign lost_d    = in_v && state_q != IDLE;
`endif
    always_comb begin
        state_d = state_q;
        coins_d = coins_q;
        stock_d = stock_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = cap_v ? (do_vend ? MOTOR : COIN_ON) : IDLE;
                // An unserved vend on an empty machine refunds the price as extra coins.
                coins_d = cap_v ? {1'b0, cap_req.change} + (cap_req.vend && !do_vend ? 3'(PRICE_COINS) : 3'd0) : coins_q;
                stock_d = refill_ok && bus.refill ? STOCK_W'(STOCK_INIT) : stock_q;
            end
            MOTOR: if (expire) begin
                state_d = GAP;
                stock_d = stock_q != '0 ? stock_q - STOCK_W'(1) : stock_q;
            end
            COIN_ON: if (expire) begin
                state_d = COIN_GAP;
                coins_d = coins_q - 3'd1;
            end
            GAP, COIN_GAP: if (expire) state_d = coins_q != 3'd0 ? COIN_ON : DONE;
            default: state_d = IDLE;
        endcase
    end
    assign t_load = state_d == MOTOR ? TW'(MOTOR_CYCLES) : state_d == COIN_ON ? TW'(COIN_CYCLES) : TW'(GAP_CYCLES);
    temporizador_ciclos #(.W(TW)) u_tmr (
        .clk      (clk),
        .rst      (rst),
        .start_i  (state_d != state_q),
        .load_i   (t_load),
        .expire_o (expire)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state_q <= IDLE;
            coins_q <= '0;
            stock_q <= STOCK_W'(STOCK_INIT);
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            coins_q <= coins_d;
            stock_q <= stock_d;
            lost_q  <= lost_d;
        end
    assign bus.busy     = state_q != IDLE;
    assign bus.motor    = state_q == MOTOR;
    assign bus.coin_out = state_q == COIN_ON;
    assign bus.done     = state_q == DONE;
    assign bus.lost     = lost_q;
    assign bus.stock    = stock_q;
    assign bus.empty    = stock_q == '0;
endmodule

// File: tb/tb_controlador_dispensador.sv
// tb_controlador_dispensador: directed bench for the dispenser sequencer (default and STOCK_INIT=1 instances)
module tb_controlador_dispensador;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   s0 = 15;
    always #5 clk = ~clk;
    controlador_dispensador_if #(.STOCK_W(4)) bus0 ();
    controlador_dispensador_if #(.STOCK_W(4)) bus1 ();
    controlador_dispensador u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    controlador_dispensador #(.STOCK_INIT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus0.vend_req = 0; bus0.change_req = 0; bus0.refill = 0;
        bus1.vend_req = 0; bus1.change_req = 0; bus1.refill = 0;
        rst = 0;
        repeat (2) tick();
        checks++;
        if ({bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost} !== 5'b0) begin
            errors++; $display("FAIL reset_outs: got %b want 00000", {bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost});
        end
        checks++;
        if (bus0.stock !== 4'd15 || bus0.empty !== 1'b0) begin
            errors++; $display("FAIL reset_stock: got stock=%0d empty=%b want 15/0", bus0.stock, bus0.empty);
        end
        checks++;
        if (bus1.stock !== 4'd1 || bus1.busy !== 1'b0) begin
            errors++; $display("FAIL reset_stock1: got stock=%0d busy=%b want 1/0", bus1.stock, bus1.busy);
        end
        @(negedge clk);
        rst = 1;
        tick();
        checks++;
        if (bus0.busy !== 1'b0 || bus0.stock !== 4'd15) begin
            errors++; $display("FAIL reset_release: got busy=%b stock=%0d want 0/15", bus0.busy, bus0.stock);
        end
    endtask

    task automatic test_vend();
        logic [4:0] e;
        logic [3:0] es;
        bus0.vend_req = 1;
        tick();
        bus0.vend_req = 0;
        for (int c = 1; c <= 13; c++) begin
            e  = {c <= 11, c <= 8, 1'b0, c == 11, 1'b0};
            es = c >= 9 ? 4'(s0 - 1) : 4'(s0);
            checks++;
            if ({bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost} !== e) begin
                errors++; $display("FAIL vend_outs c%0d: got %b want %b", c, {bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost}, e);
            end
            checks++;
            if (bus0.stock !== es) begin
                errors++; $display("FAIL vend_stock c%0d: got %0d want %0d", c, bus0.stock, es);
            end
            tick();
        end
        s0--;
    endtask

    task automatic test_change();
        logic [4:0] e;
        bus0.change_req = 2;
        tick();
        bus0.change_req = 0;
        for (int c = 1; c <= 14; c++) begin
            e = {c <= 13, 1'b0, (c <= 4) || (c >= 7 && c <= 10), c == 13, 1'b0};
            checks++;
            if ({bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost} !== e) begin
                errors++; $display("FAIL change_outs c%0d: got %b want %b", c, {bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost}, e);
            end
            checks++;
            if (bus0.stock !== 4'(s0)) begin
                errors++; $display("FAIL change_stock c%0d: got %0d want %0d", c, bus0.stock, s0);
            end
            tick();
        end
    endtask

    task automatic test_collision();
        logic [4:0] e;
        logic [3:0] es;
        bus0.vend_req = 1;
        tick();
        bus0.vend_req = 0;
        for (int c = 1; c <= 24; c++) begin
`ifdef VEND_QUEUE_EN
            e  = {c <= 22, c <= 8 || (c >= 12 && c <= 19), 1'b0, c == 11 || c == 22, 1'b0};
            es = c >= 20 ? 4'(s0 - 2) : c >= 9 ? 4'(s0 - 1) : 4'(s0);
`else
            e  = {c <= 11, c <= 8, 1'b0, c == 11, c == 4};
            es = c >= 9 ? 4'(s0 - 1) : 4'(s0);
`endif
            checks++;
            if ({bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost} !== e) begin
                errors++; $display("FAIL collision_outs c%0d: got %b want %b", c, {bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost}, e);
            end
            checks++;
            if (bus0.stock !== es) begin
                errors++; $display("FAIL collision_stock c%0d: got %0d want %0d", c, bus0.stock, es);
            end
            bus0.vend_req = (c == 3);
            tick();
        end
`ifdef VEND_QUEUE_EN
        s0 -= 2;
`else
        s0 -= 1;
`endif
    endtask

    task automatic test_refill_vend();
        logic [4:0] e;
        logic [3:0] es;
        bus0.vend_req = 1;
        bus0.refill   = 1;
        tick();
        bus0.vend_req = 0;
        bus0.refill   = 0;
        for (int c = 1; c <= 12; c++) begin
            e  = {c <= 11, c <= 8, 1'b0, c == 11, 1'b0};
            es = c >= 9 ? 4'(s0 - 1) : 4'(s0);
            checks++;
            if ({bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost} !== e) begin
                errors++; $display("FAIL refill_vend_outs c%0d: got %b want %b", c, {bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost}, e);
            end
            checks++;
            if (bus0.stock !== es) begin
                errors++; $display("FAIL refill_vend_stock c%0d: got %0d want %0d", c, bus0.stock, es);
            end
            tick();
        end
        s0--;
    endtask

    task automatic test_refill_coin();
        logic [4:0] e;
        bus0.change_req = 1;
        tick();
        bus0.change_req = 0;
        for (int c = 1; c <= 8; c++) begin
            e = {c <= 7, 1'b0, c <= 4, c == 7, 1'b0};
            checks++;
            if ({bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost} !== e) begin
                errors++; $display("FAIL refill_coin_outs c%0d: got %b want %b", c, {bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost}, e);
            end
            checks++;
            if (bus0.stock !== 4'(s0)) begin
                errors++; $display("FAIL refill_coin_stock c%0d: got %0d want %0d", c, bus0.stock, s0);
            end
            bus0.refill = (c == 2);
            tick();
        end
        bus0.refill = 0;
    endtask

    task automatic test_reset_mid();
        bus0.vend_req = 1;
        tick();
        bus0.vend_req = 0;
        tick();
        tick();
        checks++;
        if (bus0.motor !== 1'b1) begin
            errors++; $display("FAIL reset_mid_pre: got motor=%b want 1", bus0.motor);
        end
        rst = 0;
        #2;
        checks++;
        if ({bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_outs: got %b want 00000", {bus0.busy, bus0.motor, bus0.coin_out, bus0.done, bus0.lost});
        end
        checks++;
        if (bus0.stock !== 4'd15 || bus0.empty !== 1'b0) begin
            errors++; $display("FAIL reset_mid_stock: got stock=%0d empty=%b want 15/0", bus0.stock, bus0.empty);
        end
        @(negedge clk);
        rst = 1;
        tick();
        checks++;
        if (bus0.busy !== 1'b0 || bus0.motor !== 1'b0) begin
            errors++; $display("FAIL reset_mid_after: got busy=%b motor=%b want 0/0", bus0.busy, bus0.motor);
        end
        s0 = 15;
    endtask

    task automatic test_empty_refund();
        logic [4:0] e;
        bus1.vend_req = 1;
        tick();
        bus1.vend_req = 0;
        repeat (11) tick();
        checks++;
        if (bus1.stock !== 4'd0 || bus1.empty !== 1'b1 || bus1.busy !== 1'b0) begin
            errors++; $display("FAIL empty_after_vend: got stock=%0d empty=%b busy=%b want 0/1/0", bus1.stock, bus1.empty, bus1.busy);
        end
        bus1.vend_req   = 1;
        bus1.change_req = 1;
        tick();
        bus1.vend_req   = 0;
        bus1.change_req = 0;
        for (int c = 1; c <= 26; c++) begin
            e = {c <= 25, 1'b0, c <= 22 && ((c - 1) % 6) < 4, c == 25, 1'b0};
            checks++;
            if ({bus1.busy, bus1.motor, bus1.coin_out, bus1.done, bus1.lost} !== e) begin
                errors++; $display("FAIL refund_outs c%0d: got %b want %b", c, {bus1.busy, bus1.motor, bus1.coin_out, bus1.done, bus1.lost}, e);
            end
            checks++;
            if (bus1.stock !== 4'd0) begin
                errors++; $display("FAIL refund_stock c%0d: got %0d want 0", c, bus1.stock);
            end
            tick();
        end
        bus1.refill = 1;
        tick();
        bus1.refill = 0;
        checks++;
        if (bus1.stock !== 4'd1 || bus1.empty !== 1'b0 || bus1.busy !== 1'b0) begin
            errors++; $display("FAIL empty_refill: got stock=%0d empty=%b busy=%b want 1/0/0", bus1.stock, bus1.empty, bus1.busy);
        end
    endtask

    initial begin
        test_reset();
        test_vend();
        test_change();
        test_collision();
        test_refill_vend();
        test_refill_coin();
        test_reset_mid();
        test_empty_refund();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
